// File: rtl/cwd_issue_buf_pkg.sv
// Entry layout and helpers shared by the codeword issue buffer and its storage.
`ifndef CWD_DEFINE_V
`include "define.v"
`endif

package cwd_issue_buf_pkg;

  localparam int CWD_ARR_BW = `NUM_PQ * `CWD_BW;

  typedef struct packed {
    logic [CWD_ARR_BW-1:0] cwd;
    logic [`TIME_BW-1:0]   timing;
    logic [`OPCODE_BW-1:0] opcode;
  } cwd_entry_t;

  localparam int ENTRY_BW = $bits(cwd_entry_t);

  function automatic logic [CWD_ARR_BW-1:0] idle_cwd();
    idle_cwd = {`NUM_PQ{`CWD_I}};
  endfunction

endpackage

// File: rtl/cwd_issue_buf_fifo.sv
// Entry storage: 2^ADDR_BW deep FIFO, head readable combinationally, registered count.
// Latency push->head 1 cycle; push ignored when full, pop ignored when empty.
module cwdissue_fifo #(
  parameter int ADDR_BW = 2,
  parameter int DATA_BW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DATA_BW-1:0] push_data,
  input  logic               pop,
  output logic [DATA_BW-1:0] head_data,
  output logic [ADDR_BW:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 1 << ADDR_BW;

  logic [DATA_BW-1:0] mem [DEPTH];
  logic [ADDR_BW-1:0] wr_ptr;
  logic [ADDR_BW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full      = (count == (ADDR_BW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/define.v
// Shared widths and constants for the codeword issue path.
`ifndef CWD_DEFINE_V
`define CWD_DEFINE_V

`define NUM_PQ            4
`define CWD_BW            8
`define TIME_BW           8
`define OPCODE_BW         4
`define INVALID_OPCODE    4'd0
`define CWD_I             8'h0F
`define CWDISSUE_DEPTH_BW 2

`endif

// File: rtl/cwd_issue_buf.sv
// Queues codeword entries and issues each once its wait time since the previous issue has elapsed;
// accept->cwd_valid >= 2 cycles, cwdgen_stall high when full. CWDISSUE_HOLD_EN: hold outputs between issues.
`ifndef CWD_DEFINE_V
`include "define.v"
`endif

module cwd_issue_buf
  import cwd_issue_buf_pkg::*;
#(
  parameter int DEPTH_BW = `CWDISSUE_DEPTH_BW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          psu_valid,
  input  logic [`NUM_PQ*`CWD_BW-1:0]    cwdarray_in,
  input  logic [`TIME_BW-1:0]           timing_in,
  input  logic [`OPCODE_BW-1:0]         opcode_in,
  input  logic                          qctrl_stall,
  output logic                          cwdgen_stall,
  output logic                          cwd_valid,
  output logic [`NUM_PQ*`CWD_BW-1:0]    cwd_out,
  output logic [`OPCODE_BW-1:0]         opcode_out,
  output logic [DEPTH_BW:0]             occupancy
);

  cwd_entry_t          push_entry;
  cwd_entry_t          head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                accept;
  logic                head_ready;
  logic                head_invalid;
  logic                issue;
  logic                drop;
  logic [`TIME_BW-1:0] wait_cnt;

  assign push_entry   = '{cwd: cwdarray_in, timing: timing_in, opcode: opcode_in};
  assign cwdgen_stall = fifo_full;
  assign accept       = psu_valid & ~cwdgen_stall;

  // Invalid-opcode heads are discarded without touching the wait counter.
  assign head_ready   = ~fifo_empty & ~qctrl_stall;
  assign head_invalid = (head.opcode == `INVALID_OPCODE);
  assign issue        = head_ready & ~head_invalid & (wait_cnt >= head.timing);
  assign drop         = head_ready & head_invalid;

  cwdissue_fifo #(
    .ADDR_BW (DEPTH_BW),
    .DATA_BW (ENTRY_BW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_entry),
    .pop       (issue | drop),
    .head_data (head),
    .count     (occupancy),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (issue) begin
      wait_cnt <= '0;
    end else if (!qctrl_stall && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cwd_valid  <= 1'b0;
      cwd_out    <= idle_cwd();
      opcode_out <= `INVALID_OPCODE;
    end else begin
      cwd_valid <= issue;
      if (issue) begin
        cwd_out    <= head.cwd;
        opcode_out <= head.opcode;
      end else begin
`ifdef CWDISSUE_HOLD_EN
        cwd_out    <= cwd_out;
        opcode_out <= opcode_out;
`else
        cwd_out    <= idle_cwd();
        opcode_out <= `INVALID_OPCODE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cwd_issue_buf.sv
// Directed bench for cwd_issue_buf: issue timing, backpressure, invalid drop, saturation, reset.
`ifndef CWD_DEFINE_V
`include "define.v"
`endif

module tb_cwd_issue_buf;

  localparam int DBW = 2;
  localparam int AW  = `NUM_PQ * `CWD_BW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  psu_valid = 1'b0;
  logic [AW-1:0]         cwdarray_in = '0;
  logic [`TIME_BW-1:0]   timing_in = '0;
  logic [`OPCODE_BW-1:0] opcode_in = '0;
  logic                  qctrl_stall = 1'b0;
  logic                  cwdgen_stall;
  logic                  cwd_valid;
  logic [AW-1:0]         cwd_out;
  logic [`OPCODE_BW-1:0] opcode_out;
  logic [DBW:0]          occupancy;

  int errors = 0;
  int checks = 0;

  int            pc[$];
  logic [AW-1:0] pd[$];
  logic [AW-1:0] e_dat [5];
  logic [AW-1:0] idle_c;
  logic [AW-1:0] exp_out;
  logic [`OPCODE_BW-1:0] exp_op;

  cwd_issue_buf #(.DEPTH_BW(DBW)) dut (
    .clk          (clk),
    .rst          (rst),
    .psu_valid    (psu_valid),
    .cwdarray_in  (cwdarray_in),
    .timing_in    (timing_in),
    .opcode_in    (opcode_in),
    .qctrl_stall  (qctrl_stall),
    .cwdgen_stall (cwdgen_stall),
    .cwd_valid    (cwd_valid),
    .cwd_out      (cwd_out),
    .opcode_out   (opcode_out),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] c, input logic [`TIME_BW-1:0] t,
                       input logic [`OPCODE_BW-1:0] op);
    psu_valid   = v;
    cwdarray_in = c;
    timing_in   = t;
    opcode_in   = op;
  endtask

  // Records the cycle index and data of every cwd_valid pulse in [first, last].
  task automatic capture(input int first, input int last);
    pc.delete();
    pd.delete();
    for (int c = first; c <= last; c++) begin
      if (cwd_valid) begin
        pc.push_back(c);
        pd.push_back(cwd_out);
      end
      step();
    end
  endtask

  initial begin
    idle_c   = {`NUM_PQ{`CWD_I}};
    e_dat[0] = 32'hE000_0001;
    e_dat[1] = 32'hE111_0002;
    e_dat[2] = 32'hE222_0003;
    e_dat[3] = 32'hE333_0004;
    e_dat[4] = 32'hE444_0005;

    // Reset state
    step();
    step();
    chk("rst_valid", cwd_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_stall", cwdgen_stall, 0);
    chk("rst_cwd", cwd_out, idle_c);
    chk("rst_op", opcode_out, `INVALID_OPCODE);
    rst = 1'b1;
    step();

    // Single entry, timing 0: pulse two cycles after accept
    drive(1, 32'hA1A2A3A4, 0, 1);
    step();
    drive(0, 0, 0, 0);
    chk("t1_occ1", occupancy, 1);
    chk("t1_early", cwd_valid, 0);
    step();
    chk("t1_valid", cwd_valid, 1);
    chk("t1_cwd", cwd_out, 32'hA1A2A3A4);
    chk("t1_op", opcode_out, 1);
    chk("t1_wait", dut.wait_cnt, 0);
    chk("t1_occ0", occupancy, 0);
    step();
`ifdef CWDISSUE_HOLD_EN
    exp_out = 32'hA1A2A3A4;
    exp_op  = 1;
`else
    exp_out = idle_c;
    exp_op  = `INVALID_OPCODE;
`endif
    chk("t1_pulse_end", cwd_valid, 0);
    chk("t1_cwd_after", cwd_out, exp_out);
    chk("t1_op_after", opcode_out, exp_op);

    // Back-to-back timing 0 then 5: issues at cycles 2 and 8
    repeat (3) step();
    drive(1, 32'hB0B0B0B0, 0, 2);
    step();
    drive(1, 32'hC0C0C0C0, 5, 3);
    step();
    drive(0, 0, 0, 0);
    capture(2, 12);
    chk("t2_npulse", pc.size(), 2);
    chk("t2_first", pc.size() > 0 ? pc[0] : -1, 2);
    chk("t2_second", pc.size() > 1 ? pc[1] : -1, 8);
    chk("t2_data", pc.size() > 1 ? pd[1] : '0, 32'hC0C0C0C0);

    // Fill under qctrl_stall, fifth entry held until a slot frees
    qctrl_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_not_full", cwdgen_stall, 0);
      drive(1, e_dat[i], 0, 4);
      step();
      chk("t3_occ", occupancy, i + 1);
    end
    chk("t3_full", cwdgen_stall, 1);
    drive(1, e_dat[4], 0, 4);
    step();
    chk("t3_held_occ", occupancy, 4);
    chk("t3_held_stall", cwdgen_stall, 1);
    chk("t3_no_issue", cwd_valid, 0);
    step();
    chk("t3_held_occ2", occupancy, 4);
    qctrl_stall = 1'b0;
    step();
    chk("t3_rel_valid", cwd_valid, 1);
    chk("t3_rel_cwd", cwd_out, e_dat[0]);
    chk("t3_rel_occ", occupancy, 3);
    chk("t3_rel_stall", cwdgen_stall, 0);
    step();
    drive(0, 0, 0, 0);
    chk("t3_e1_cwd", cwd_out, e_dat[1]);
    chk("t3_e1_occ", occupancy, 3);
    for (int k = 2; k < 5; k++) begin
      step();
      chk("t3_drain_valid", cwd_valid, 1);
      chk("t3_drain_cwd", cwd_out, e_dat[k]);
      chk("t3_drain_occ", occupancy, 4 - k);
    end
    step();
    chk("t3_no_dup", cwd_valid, 0);

    // Invalid-opcode head between two valid entries
    repeat (2) step();
    drive(1, 32'hF0F0F0F0, 0, 1);
    step();
    drive(1, 32'hDEADBEEF, 0, `INVALID_OPCODE);
    step();
    drive(1, 32'h12345678, 3, 3);
    chk("t4_first", cwd_valid, 1);
    step();
    drive(0, 0, 0, 0);
    capture(3, 12);
    chk("t4_npulse", pc.size(), 1);
    chk("t4_second", pc.size() > 0 ? pc[0] : -1, 6);
    chk("t4_data", pc.size() > 0 ? pd[0] : '0, 32'h12345678);

    // Wait counter saturates rather than wrapping
    repeat (300) step();
    chk("sat_wait", dut.wait_cnt, 8'hFF);
    drive(1, 32'h5A5A5A5A, 8'hFF, 5);
    step();
    drive(0, 0, 0, 0);
    chk("sat_early", cwd_valid, 0);
    step();
    chk("sat_valid", cwd_valid, 1);
    chk("sat_cwd", cwd_out, 32'h5A5A5A5A);

    // Reset with three entries queued discards them
    qctrl_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, e_dat[i], 0, 7);
      step();
    end
    drive(0, 0, 0, 0);
    chk("t5_occ3", occupancy, 3);
    rst = 1'b0;
    step();
    chk("t5_rst_occ", occupancy, 0);
    chk("t5_rst_stall", cwdgen_stall, 0);
    chk("t5_rst_valid", cwd_valid, 0);
    rst = 1'b1;
    qctrl_stall = 1'b0;
    capture(0, 7);
    chk("t5_no_issue", pc.size(), 0);
    drive(1, 32'h77665544, 0, 6);
    step();
    drive(0, 0, 0, 0);
    step();
    chk("t5_new_valid", cwd_valid, 1);
    chk("t5_new_cwd", cwd_out, 32'h77665544);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
